instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Sequential instruction encoder/loader: takes decoded instruction fields (class, registers, funct3, immediate) over a valid/ready handshake and assembles RV32I machine words.
- Writes encoded words into instruction memory at consecutive word addresses.
- Performs the inverse of the main decoder's opcode-to-control mapping, covering the same five classes: load, store, R-type, I-type ALU, branch.
- Used for bring-up and self-test: fills imem before the core is released from reset.

Parameters:
- DEPTH, 64, number of 32-bit words the loader may write before reporting full.
- ADDR_W, 8, width of byte address driven to imem.
- BASE_ADDR, 0, byte address of the first word written (word aligned).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous restart: address, count and err return to reset values.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  loader can accept a bundle this cycle.
- in_class  input  3  0=LW, 1=SW, 2=R, 3=I, 4=BR; 5-7 illegal.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field, passed through unchanged.
- funct7b5  input  1  bit 30 (sub/sra select) for R and shift-I.
- imm  input  13  signed immediate; bit 0 used only by non-branch classes.
- imem_we  output  1  one-cycle write strobe.
- imem_addr  output  ADDR_W  byte address of the write.
- imem_wdata  output  32  encoded instruction.
- count  output  clog2(DEPTH+1)  words written since reset/clear.
- full  output  1  count == DEPTH.
- err  output  1  sticky: illegal class (or range fault, see below) seen.

Behaviour:
- Reset values: in_ready=0 during rst, then 1 from IDLE; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0; count=0; full=0; err=0; state=IDLE.
- States: IDLE, WRITE.
- in_ready = (state==IDLE) && !full && !clear.
- Accept occurs when in_valid && in_ready at a clock edge.

Encoding on accept; word is registered into imem_wdata:
- LW: {imm[11:0], rs1, funct3, rd, 7'b0000011}
- SW: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
- R: {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011}
- I: {imm[11:0], rs1, funct3, rd, 7'b0010011}; when funct3 is 001 or 101, bits 31:25 = {1'b0, funct7b5, 5'b0} and bits 24:20 = imm[4:0].
- BR: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}; imm[0] is ignored.

Transitions and timing:
- Legal class accepted: state goes to WRITE. imem_we=1 for exactly one cycle, with imem_addr = current pointer.
- Edge leaving WRITE: pointer += 4, count += 1, state returns to IDLE.
- Throughput is one word per 2 cycles; latency from accept to imem_we high is 1 cycle.
- Illegal class accepted: no write, err <= 1, state stays IDLE, pointer and count unchanged.
- full: once count == DEPTH, in_ready stays 0 until clear or rst. in_valid while full is ignored without error.
- Pointer wrap: not possible. The highest address written is BASE_ADDR + 4*(DEPTH-1), which must fit in ADDR_W (integration constraint).
- clear: highest priority after rst. Any state goes to IDLE, any pending WRITE strobe is suppressed, pointer=BASE_ADDR, count=0, full=0, err=0. clear with in_valid in the same cycle: no accept.
- rst mid-WRITE: strobe drops immediately (async); all outputs take reset values.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined:
  - LW/SW/I: imm[12] != imm[11] is a range fault.
  - I-shift: imm[11:5] != 0 is a range fault.
  - BR: imm[0] != 0 is a range fault.
  - A range fault sets err, produces no write, and the pointer is unchanged.
- Undefined: immediates are truncated as listed; no fault is raised.

Test Plan:
- LW rd=6, rs1=9, f3=010, imm=-4 -> imem_wdata=0xFFC4A303, imem_addr=0x00, count=1.
- SW rs2=6, rs1=9, f3=010, imm=8 -> 0x0064A423 at 0x04. Then R rd=2, rs1=3, rs2=4, f3=0, funct7b5=1 -> 0x40418133 at 0x08.
- BR rs1=1, rs2=2, f3=000, imm=8 -> 0x00208463. I rd=5, rs1=0, f3=000, imm=1 -> 0x00100293. Check in_ready low in each WRITE cycle.
- in_class=6 -> err=1, imem_we never asserted, count unchanged. clear -> err=0, next word written at 0x00.
- 64 back-to-back legal bundles -> last at addr 0xFC, full=1, in_ready=0. A 65th valid is ignored and err stays 0.
- Assert rst during WRITE -> imem_we falls the same cycle, count=0. With IMM_RANGE_CHECK_EN, LW imm=0x0800 -> err=1, no write.

Source files
------------

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: assembles RV32I machine words (LW, SW, R, I-ALU, BR)
// from decoded fields and writes them to consecutive imem word addresses.
// One word is written every two cycles: accept in IDLE, strobe in WRITE.
// Optional build macro IMM_RANGE_CHECK_EN turns immediates that do not fit
// their encoding into a sticky error instead of silently truncating them.
module instr_encode_loader #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_class,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 rs1,
    input  logic [4:0]                 rs2,
    input  logic [2:0]                 funct3,
    input  logic                       funct7b5,
    input  logic [12:0]                imm,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       err
);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr_p0;
    logic [CNT_W-1:0]  cnt_p0;
    logic              err_p0;
    logic [31:0]       wdata_p0;
    logic              accept, legal, range_fault, do_write, is_shift;

    // Shift-immediate forms of the I class carry funct7 in the upper bits.
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Field placement for each instruction class.
    function automatic logic [31:0] encode(input logic [2:0] cls);
        logic [31:0] w;
        w = 32'h0;
        case (cls)
            3'd0: w = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            3'd1: w = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            3'd2: w = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, 7'b0110011};
            3'd3: begin
                if (is_shift)
                    w = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, 7'b0010011};
                else
                    w = {imm[11:0], rs1, funct3, rd, 7'b0010011};
            end
            3'd4: w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    // Flag immediates that the selected encoding cannot represent.
    always_comb begin
        range_fault = 1'b0;
        case (in_class)
            3'd0, 3'd1: range_fault = (imm[12] != imm[11]);
            3'd3: begin
                if (is_shift)
                    range_fault = (imm[11:5] != 7'd0);
                else
                    range_fault = (imm[12] != imm[11]);
            end
            3'd4: range_fault = imm[0];
            default: range_fault = 1'b0;
        endcase
    end
`else
    assign range_fault = 1'b0;
`endif

    assign full      = (cnt_p0 == CNT_W'(DEPTH));
    assign in_ready  = (state == IDLE) && !full && !clear && !rst;
    assign accept    = in_valid && in_ready;
    assign legal     = (in_class <= 3'd4);
    assign do_write  = accept && legal && !range_fault;
    assign imem_we   = (state == WRITE) && !clear;
    assign imem_addr = ptr_p0;
    assign imem_wdata = wdata_p0;
    assign count     = cnt_p0;
    assign err       = err_p0;

    // Next-state: clear forces IDLE; a writable bundle moves to WRITE for one cycle.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (do_write) state_nx = WRITE;
                WRITE:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State, write pointer, word count, sticky error and registered word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr_p0   <= ADDR_W'(BASE_ADDR);
            cnt_p0   <= '0;
            err_p0   <= 1'b0;
            wdata_p0 <= 32'h0;
        end else begin
            state <= state_nx;
            if (clear) begin
                ptr_p0 <= ADDR_W'(BASE_ADDR);
                cnt_p0 <= '0;
                err_p0 <= 1'b0;
            end else begin
                if (state == WRITE) begin
                    ptr_p0 <= ptr_p0 + ADDR_W'(4);
                    cnt_p0 <= cnt_p0 + CNT_W'(1);
                end
                if (accept && (!legal || range_fault))
                    err_p0 <= 1'b1;
                if (do_write)
                    wdata_p0 <= encode(in_class);
            end
        end
    end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: directed vectors, a randomized
// stream checked against a field-arithmetic reference encoder, fill-to-full,
// clear, and reset during a write strobe.
module tb_instr_encode_loader;
    localparam int DEPTH = 64;

    logic        clk = 0, rst = 1, clear = 0, in_valid = 0;
    logic        in_ready;
    logic [2:0]  in_class = 0, funct3 = 0;
    logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
    logic        funct7b5 = 0;
    logic [12:0] imm = 0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;
    logic        full, err;

    int nchk = 0, npass = 0;
    int mcount = 0;

    instr_encode_loader #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7b5(funct7b5), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference encoder: builds the word by shifting each field to its bit offset.
    function automatic logic [31:0] ref_word(input int cls, input int r_d, input int r_s1,
                                             input int r_s2, input int f3, input int f7,
                                             input logic [12:0] im);
        int b;
        b = int'(im);
        case (cls)
            0: return 32'h03 | (r_d << 7) | (f3 << 12) | (r_s1 << 15) | ((b & 'hFFF) << 20);
            1: return 32'h23 | ((b & 31) << 7) | (f3 << 12) | (r_s1 << 15) | (r_s2 << 20)
                      | (((b >> 5) & 127) << 25);
            2: return 32'h33 | (r_d << 7) | (f3 << 12) | (r_s1 << 15) | (r_s2 << 20) | (f7 << 30);
            3: if (f3 == 1 || f3 == 5)
                   return 32'h13 | (r_d << 7) | (f3 << 12) | (r_s1 << 15) | ((b & 31) << 20)
                          | (f7 << 30);
               else
                   return 32'h13 | (r_d << 7) | (f3 << 12) | (r_s1 << 15) | ((b & 'hFFF) << 20);
            4: return 32'h63 | (((b >> 11) & 1) << 7) | (((b >> 1) & 15) << 8) | (f3 << 12)
                      | (r_s1 << 15) | (r_s2 << 20) | (((b >> 5) & 63) << 25)
                      | (((b >> 12) & 1) << 31);
            default: return 32'h0;
        endcase
    endfunction

    // Present one bundle, wait (bounded) for acceptance, then check the write or the error.
    task automatic send(input string tag, input int cls, input int r_d, input int r_s1,
                        input int r_s2, input int f3, input int f7, input logic [12:0] im,
                        input logic [31:0] exp_w, input bit exp_wr);
        int n;
        @(negedge clk);
        in_class = 3'(cls); rd = 5'(r_d); rs1 = 5'(r_s1); rs2 = 5'(r_s2);
        funct3 = 3'(f3); funct7b5 = f7[0]; imm = im; in_valid = 1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check({tag, "_ready_timeout"}, 0, 1);
            in_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        if (exp_wr) begin
            check({tag, "_we"}, 32'(imem_we), 1);
            check({tag, "_addr"}, 32'(imem_addr), 32'(4 * mcount));
            check({tag, "_data"}, imem_wdata, exp_w);
            check({tag, "_ready_in_write"}, 32'(in_ready), 0);
            @(posedge clk);
            #1;
            mcount++;
            check({tag, "_we_drop"}, 32'(imem_we), 0);
            check({tag, "_count"}, 32'(count), 32'(mcount));
        end else begin
            check({tag, "_no_we"}, 32'(imem_we), 0);
            check({tag, "_err"}, 32'(err), 1);
            check({tag, "_count_hold"}, 32'(count), 32'(mcount));
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1;
        in_valid = 1;
        #1;
        check("clear_ready", 32'(in_ready), 0);
        @(negedge clk);
        clear = 0;
        in_valid = 0;
        mcount = 0;
        check("clear_err", 32'(err), 0);
        check("clear_count", 32'(count), 0);
        check("clear_addr", 32'(imem_addr), 0);
        check("clear_we", 32'(imem_we), 0);
    endtask

    // Random bundle with an immediate that fits its class, so every build writes it.
    task automatic send_random(input string tag, input bit allow_illegal);
        int cls, f3, r_d, r_s1, r_s2, f7;
        logic [11:0] x;
        logic [12:0] im;
        cls  = allow_illegal ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 4));
        f3   = int'($urandom_range(0, 7));
        r_d  = int'($urandom_range(0, 31));
        r_s1 = int'($urandom_range(0, 31));
        r_s2 = int'($urandom_range(0, 31));
        f7   = int'($urandom_range(0, 1));
        x    = 12'($urandom);
        im   = {x[11], x};
        if (cls == 3 && (f3 == 1 || f3 == 5)) im = 13'($urandom_range(0, 31));
        if (cls == 4) im = 13'($urandom) & 13'h1FFE;
        send(tag, cls, r_d, r_s1, r_s2, f3, f7, im,
             ref_word(cls, r_d, r_s1, r_s2, f3, f7, im), cls <= 4);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_err", 32'(err), 0);
        rst = 0;
        #1;
        check("idle_ready", 32'(in_ready), 1);

        // Directed vectors
        send("lw", 0, 6, 9, 0, 2, 0, -13'sd4, 32'hFFC4A303, 1);
        send("sw", 1, 0, 9, 6, 2, 0, 13'd8, 32'h0064A423, 1);
        send("r_sub", 2, 2, 3, 4, 0, 1, 13'd0, 32'h40418133, 1);
        send("beq", 4, 0, 1, 2, 0, 0, 13'd8, 32'h00208463, 1);
        send("addi", 3, 5, 0, 0, 0, 0, 13'd1, 32'h00100293, 1);

        // Illegal class, then clear
        send("illegal", 6, 1, 2, 3, 0, 0, 13'd0, 32'h0, 0);
        do_clear();
        send("after_clear", 0, 6, 9, 0, 2, 0, -13'sd4, 32'hFFC4A303, 1);

        // Random stream including illegal classes
        for (int i = 0; i < 24; i++) send_random("rnd", 1);

        // Fill to DEPTH
        do_clear();
        for (int i = 0; i < DEPTH; i++) send_random("fill", 0);
        check("full_flag", 32'(full), 1);
        check("full_ready", 32'(in_ready), 0);
        check("full_last_addr", 32'(4 * (mcount - 1)), 32'h0FC);
        @(negedge clk);
        in_valid = 1; in_class = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_ignore_we", 32'(imem_we), 0);
        end
        in_valid = 0;
        check("full_ignore_err", 32'(err), 0);
        check("full_ignore_count", 32'(count), DEPTH);

        // Reset asserted while the write strobe is high
        do_clear();
        send("pre_rst", 2, 1, 1, 1, 0, 0, 13'd0, 32'h001080B3, 1);
        @(negedge clk);
        in_class = 2; rd = 3; rs1 = 4; rs2 = 5; funct3 = 0; funct7b5 = 0; in_valid = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        check("rst_mid_we_before", 32'(imem_we), 1);
        rst = 1;
        #1;
        check("rst_mid_we", 32'(imem_we), 0);
        check("rst_mid_count", 32'(count), 0);
        check("rst_mid_addr", 32'(imem_addr), 0);
        @(negedge clk);
        rst = 0;
        mcount = 0;
        send("post_rst", 3, 5, 0, 0, 0, 0, 13'd1, 32'h00100293, 1);

`ifdef IMM_RANGE_CHECK_EN
        send("lw_range", 0, 6, 9, 0, 2, 0, 13'h0800, 32'h0, 0);
        send("br_odd", 4, 0, 1, 2, 0, 0, 13'd9, 32'h0, 0);
        send("slli_range", 3, 1, 1, 0, 1, 0, 13'h0040, 32'h0, 0);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
